// File: rtl/l1_pkg.sv
// l1_pkg: shared definitions for the L1 loss controller.
//   IL, FL  : integer / fraction bits of the signed fixed-point word
//   size    : maximum element count per batch
//   state_e : controller FSM encoding
package l1_pkg;
  localparam int IL   = 8;
  localparam int FL   = 12;
  localparam int size = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/abs_diff_sat.sv
// abs_diff_sat: combinational |a - b| for signed W = IL+FL bit words,
// saturated to the largest positive W-bit value.
//   i_a, i_b : signed operands
//   o_abs    : saturated magnitude, always non-negative
module abs_diff_sat #(
  parameter int IL = l1_pkg::IL,
  parameter int FL = l1_pkg::FL
) (
  input  logic signed [IL+FL-1:0] i_a,
  input  logic signed [IL+FL-1:0] i_b,
  output logic        [IL+FL-1:0] o_abs
);
  localparam int W = IL + FL;
  localparam logic [W:0] MAXP = {2'b00, {(W-1){1'b1}}};

  logic [W:0] w_diff;
  logic [W:0] w_mag;

  // Sign-extend to W+1 bits so the difference never wraps.
  assign w_diff = {i_a[W-1], i_a} - {i_b[W-1], i_b};
  // |diff| <= 2^W-1 always fits in W+1 bits after negation.
  assign w_mag  = w_diff[W] ? (~w_diff + {{W{1'b0}}, 1'b1}) : w_diff;
  assign o_abs  = (w_mag > MAXP) ? MAXP[W-1:0] : w_mag[W-1:0];
endmodule

// File: rtl/l1_loss_ctrl.sv
// l1_loss_ctrl: accumulates sum(|yHat[i]-y[i]|) over a batch of up to
// `size` elements, one element per cycle, with saturating accumulation.
//   clk, reset : clock, synchronous active-high reset
//   start, num : begin a batch of min(num,size) elements (IDLE only)
//   yHat, y    : operand vectors, held stable for the whole batch
//   ack        : consumer accepts the result (DONE only)
//   busy       : RUN, DRAIN or DONE
//   done, sum  : result valid / accumulated loss, held until ack
//   ovf        : accumulator saturated during this batch
module l1_loss_ctrl #(
  parameter int IL    = l1_pkg::IL,
  parameter int FL    = l1_pkg::FL,
  parameter int size  = l1_pkg::size,
  parameter int width = $clog2(size) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [width-1:0]              num,
  input  logic [size-1:0][IL+FL-1:0]    yHat,
  input  logic [size-1:0][IL+FL-1:0]    y,
  input  logic                          ack,
  output logic                          busy,
  output logic                          done,
  output logic signed [IL+FL-1:0]       sum,
  output logic                          ovf
);
  localparam int W    = IL + FL;
  localparam int IDXW = (size > 1) ? $clog2(size) : 1;
  localparam logic [W:0] MAXP = {2'b00, {(W-1){1'b1}}};
  localparam logic [width-1:0] SIZE_W = width'(size);

  l1_pkg::state_e r_state, w_nxt;

  logic [width-1:0] r_num_l, r_idx, w_num_l;
  logic [W-1:0]     r_acc, r_abs, w_abs;
  logic             r_abs_v, r_ovf;
  logic [IDXW-1:0]  w_sel;
  logic [W:0]       w_acc_sum;
  logic             w_acc_sat;

  assign w_sel = r_idx[IDXW-1:0];

  abs_diff_sat #(.IL(IL), .FL(FL)) u_abs (
    .i_a   (yHat[w_sel]),
    .i_b   (y[w_sel]),
    .o_abs (w_abs)
  );

  // acc and abs_r are both in [0, 2^(W-1)-1], so W+1 bits cannot wrap.
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_abs};
  assign w_acc_sat = (w_acc_sum > MAXP);

  always_comb begin
    w_nxt   = r_state;
    w_num_l = (num > SIZE_W) ? SIZE_W : num;
    unique case (r_state)
      l1_pkg::IDLE:  if (start) w_nxt = (w_num_l == '0) ? l1_pkg::DONE : l1_pkg::RUN;
      l1_pkg::RUN:   if (r_idx == r_num_l - width'(1)) w_nxt = l1_pkg::DRAIN;
      l1_pkg::DRAIN: w_nxt = l1_pkg::DONE;
      l1_pkg::DONE:  if (ack) w_nxt = l1_pkg::IDLE;
      default:       w_nxt = l1_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= l1_pkg::IDLE;
      r_num_l <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_abs   <= '0;
      r_abs_v <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      // abs_r from the previous cycle is folded in one cycle later; DRAIN
      // exists only to absorb the last element.
      if (r_abs_v) begin
        r_acc <= w_acc_sat ? MAXP[W-1:0] : w_acc_sum[W-1:0];
        if (w_acc_sat) r_ovf <= 1'b1;
      end
      unique case (r_state)
        l1_pkg::IDLE: if (start) begin
          r_num_l <= w_num_l;
          r_idx   <= '0;
          r_acc   <= '0;
          r_ovf   <= 1'b0;
          r_abs_v <= 1'b0;
        end
        l1_pkg::RUN: begin
          r_abs   <= w_abs;
          r_abs_v <= 1'b1;
          r_idx   <= r_idx + width'(1);
        end
        l1_pkg::DRAIN: r_abs_v <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy = (r_state != l1_pkg::IDLE);
  assign done = (r_state == l1_pkg::DONE);
  assign sum  = r_acc;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_l1_loss_ctrl.sv
module tb_l1_loss_ctrl;
  localparam int W = 20;
  localparam int N = 16;
  localparam int MAXV = (1 << (W-1)) - 1;

  logic clk = 0, reset = 0, start = 0, ack = 0;
  logic [4:0] num = 0;
  logic [N-1:0][W-1:0] yHat, y;
  logic busy, done, ovf;
  logic signed [W-1:0] sum;

  int total = 0, bad = 0;
  int a_v[N], b_v[N];

  always #5 clk = ~clk;

  l1_loss_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .num(num), .yHat(yHat), .y(y),
    .ack(ack), .busy(busy), .done(done), .sum(sum), .ovf(ovf)
  );

  task automatic load_vecs();
    for (int i = 0; i < N; i++) begin
      yHat[i] = a_v[i][W-1:0];
      y[i]    = b_v[i][W-1:0];
    end
  endtask

  // Reference: plain integer arithmetic straight from the loss definition.
  task automatic model(input int n_in, output int s, output bit ov, output int lat);
    int n, d;
    n = (n_in > N) ? N : n_in;
    s = 0; ov = 0;
    for (int i = 0; i < n; i++) begin
      d = a_v[i] - b_v[i];
      if (d < 0) d = -d;
      if (d > MAXV) d = MAXV;
      s = s + d;
      if (s > MAXV) begin s = MAXV; ov = 1; end
    end
    lat = (n == 0) ? 1 : n + 2;
  endtask

  // Leaves the bench at the negedge of the first cycle after the start cycle.
  task automatic do_start(input int n);
    @(negedge clk); num = 5'(n); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic do_ack();
    ack = 1; @(negedge clk); ack = 0;
  endtask

  task automatic test_reset();
    reset = 1; repeat (3) @(negedge clk); reset = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (sum !== '0)    begin bad++; $display("FAIL reset_sum got=%0d want=0", sum); end
    total++; if (ovf !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
  endtask

  task automatic test_directed();
    int lat, s; bit ov; int el;
    for (int i = 0; i < N; i++) begin a_v[i] = 0; b_v[i] = 0; end
    a_v[0] = 4096; a_v[1] = 0;    a_v[2] = -2048; a_v[3] = 8192;
    b_v[0] = 0;    b_v[1] = 4096; b_v[2] = 2048;  b_v[3] = 8192;
    load_vecs();
    model(4, s, ov, el);
    do_start(4); wait_done(lat);
    total++; if (lat != 6)     begin bad++; $display("FAIL dir_latency got=%0d want=6", lat); end
    total++; if (sum !== 20'(12288)) begin bad++; $display("FAIL dir_sum got=%0d want=12288", sum); end
    total++; if (sum !== 20'(s)) begin bad++; $display("FAIL dir_sum_model got=%0d want=%0d", sum, s); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL dir_ovf got=%b want=0", ovf); end
    repeat (5) begin
      @(negedge clk);
      total++;
      if (done !== 1'b1 || sum !== 20'(12288)) begin
        bad++; $display("FAIL dir_hold done=%b sum=%0d want done=1 sum=12288", done, sum);
      end
    end
    do_ack();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL dir_ack done=%b busy=%b want 0/0", done, busy); end
    repeat (3) @(negedge clk);
    total++; if (sum !== 20'(12288)) begin bad++; $display("FAIL dir_idle_sum got=%0d want=12288", sum); end
  endtask

  task automatic test_zero();
    int lat;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_pre_busy got=%b want=0", busy); end
    do_start(0);
    lat = 1;
    total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL zero_done done=%b busy=%b want 1/1", done, busy); end
    total++; if (sum !== '0 || ovf !== 1'b0) begin bad++; $display("FAIL zero_sum sum=%0d ovf=%b want 0/0", sum, ovf); end
    do_ack();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_saturate();
    int lat;
    for (int i = 0; i < N; i++) begin a_v[i] = 524287; b_v[i] = -524288; end
    load_vecs();
    do_start(16); wait_done(lat);
    total++; if (lat != 18) begin bad++; $display("FAIL sat_latency got=%0d want=18", lat); end
    total++; if (sum !== 20'(524287)) begin bad++; $display("FAIL sat_sum got=%0d want=524287", sum); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b want=1", ovf); end
    do_ack();
  endtask

  task automatic test_clamp();
    int lat, s, el; bit ov;
    for (int i = 0; i < N; i++) begin a_v[i] = $urandom_range(0, 8191); b_v[i] = -$urandom_range(0, 8191); end
    load_vecs();
    model(20, s, ov, el);
    do_start(20); wait_done(lat);
    total++; if (lat != 18) begin bad++; $display("FAIL clamp_latency got=%0d want=18", lat); end
    total++; if (sum !== 20'(s) || ovf !== ov) begin bad++; $display("FAIL clamp_sum got=%0d/%b want=%0d/%b", sum, ovf, s, ov); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int lat, s, el; bit ov;
    for (int i = 0; i < N; i++) begin a_v[i] = $urandom_range(0, 60000); b_v[i] = $urandom_range(0, 60000); end
    load_vecs();
    model(6, s, ov, el);
    do_start(6);
    @(negedge clk); num = 5'd2; start = 1;   // during RUN: must be ignored
    @(negedge clk); start = 0;
    wait_done(lat); lat = lat + 2;
    total++; if (lat != el) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, el); end
    total++; if (sum !== 20'(s)) begin bad++; $display("FAIL b2b_sum got=%0d want=%0d", sum, s); end
    start = 1; @(negedge clk); start = 0;    // start in DONE without ack
    total++; if (done !== 1'b1 || sum !== 20'(s)) begin bad++; $display("FAIL b2b_start_in_done done=%b sum=%0d want 1/%0d", done, sum, s); end
    start = 1; ack = 1; @(negedge clk); start = 0; ack = 0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL b2b_start_ack busy=%b done=%b want 0/0", busy, done); end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_no_restart busy=%b want=0", busy); end
    model(3, s, ov, el);
    do_start(3); wait_done(lat);
    total++; if (lat != el || sum !== 20'(s)) begin bad++; $display("FAIL b2b_restart lat=%0d sum=%0d want %0d/%0d", lat, sum, el, s); end
    do_ack();
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int i = 0; i < N; i++) begin a_v[i] = 1000 * (i + 1); b_v[i] = 0; end
    load_vecs();
    do_start(8);
    @(negedge clk); @(negedge clk);          // now in the 3rd RUN cycle
    reset = 1; @(negedge clk); reset = 0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || sum !== '0) begin
      bad++; $display("FAIL midreset busy=%b done=%b sum=%0d want 0/0/0", busy, done, sum);
    end
    seen = 0;
    repeat (20) begin @(negedge clk); if (done) seen = 1; end
    total++; if (seen != 0) begin bad++; $display("FAIL midreset_no_done got done within 20 cycles"); end
  endtask

  task automatic test_random();
    int lat, s, el, n; bit ov;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) begin
        a_v[i] = int'($urandom_range(0, (1 << 19) - 1)) - (1 << 18);
        b_v[i] = int'($urandom_range(0, (1 << 19) - 1)) - (1 << 18);
      end
      load_vecs();
      n = $urandom_range(0, 20);
      model(n, s, ov, el);
      do_start(n); wait_done(lat);
      total++;
      if (lat != el || sum !== 20'(s) || ovf !== ov) begin
        bad++; $display("FAIL rand_%0d n=%0d lat=%0d sum=%0d ovf=%b want %0d/%0d/%b", t, n, lat, sum, ovf, el, s, ov);
      end
      do_ack();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin a_v[i] = 0; b_v[i] = 0; end
    load_vecs();
    test_reset();
    test_directed();
    test_zero();
    test_saturate();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l1_loss_ctrl.md
L1_LOSS_CTRL -- requirements
Module: l1_loss_ctrl

Interface
REQ-001 The block SHALL take parameter IL, default 8, meaning integer bits of the signed fixed-point format.
REQ-002 The block SHALL take parameter FL, default 12, meaning fraction bits; word width W = IL+FL.
REQ-003 The block SHALL take parameter size, default 16, meaning maximum element count per batch.
REQ-004 The block SHALL take parameter width, default $clog2(size)+1, meaning width of num and of the index counter.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 Ports:
  - clk  input  1  rising-edge clock.
  - reset  input  1  synchronous, active-high reset.
  - start  input  1  one-cycle request to begin a batch.
  - num  input  width  element count, sampled with start.
  - yHat  input  signed W x size  predictions, held stable from start until done.
  - y  input  signed W x size  targets, held stable from start until done.
  - ack  input  1  consumer accepts the result.
  - busy  output  1  high in RUN, DRAIN and DONE.
  - done  output  1  result valid; held until ack.
  - sum  output  signed W  accumulated L1 loss.
  - ovf  output  1  sticky saturation flag for the current batch.

Function
REQ-007 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-008 In IDLE, start=1 SHALL latch the element count num_l = min(num, size), clear acc, ovf, idx and abs_v, and move the FSM to RUN, or to DONE if num_l=0.
REQ-009 In RUN, each cycle SHALL register abs_r = |yHat[idx]-y[idx]|, set abs_v=1 and increment idx; when idx = num_l-1 the FSM SHALL move to DRAIN.
REQ-010 The difference SHALL be computed in W+1 bits, and any magnitude above 2^(W-1)-1 SHALL saturate to 2^(W-1)-1.
REQ-011 Whenever abs_v=1, acc SHALL be updated to acc+abs_r, computed in W+1 bits and saturated at 2^(W-1)-1; saturation SHALL set ovf.
REQ-012 In DRAIN, the final abs_r SHALL be accumulated, abs_v SHALL clear, and the FSM SHALL move to DONE.
REQ-013 In DONE, done=1 and sum=acc SHALL hold stable until ack=1; on ack the FSM SHALL move to IDLE.
REQ-014 Latency: for num_l>=1, done SHALL rise num_l+2 cycles after the start cycle; for num_l=0, it SHALL rise 1 cycle after, with sum=0.
REQ-015 start SHALL be ignored when the FSM is not in IDLE.
REQ-016 ack SHALL be ignored outside DONE.
REQ-017 start and ack asserted in the same DONE cycle SHALL complete the current result only; no new batch starts.
REQ-018 sum SHALL never be negative; the accumulation SHALL be monotonic non-decreasing.
REQ-019 sum SHALL retain its last value in IDLE until the next start.

Reset
REQ-020 reset=1 SHALL, at the next rising edge, force the FSM to IDLE and clear to 0: busy, done, sum, ovf, acc, idx, num_l, abs_r, abs_v.
REQ-021 Reset SHALL take priority over start and ack.
REQ-022 Reset asserted mid-batch SHALL abort the batch; no done pulse SHALL follow.

Structure
REQ-023 IL, FL, size and the state enum type SHALL be defined in shared package l1_pkg.
REQ-024 The saturating absolute difference SHALL be implemented in sub-module abs_diff_sat, purely combinational, with parameters IL and FL.
REQ-025 All state SHALL be held in a single always_ff block, with next-state logic in always_comb.

Verification
REQ-026 num=4, yHat={4096,0,-2048,8192}, y={0,4096,2048,8192}, ack held low -> done rises 6 cycles after start, sum=12288, ovf=0; done and sum hold stable until ack.
REQ-027 num=0, then start -> done 1 cycle later, sum=0, ovf=0, busy high for exactly 1 cycle before ack.
REQ-028 num=16, all yHat=524287, all y=-524288 -> each abs saturates to 524287, sum=524287, ovf=1.
REQ-029 num=20 -> num_l is clamped to 16, and done arrives 18 cycles after start.
REQ-030 A second start during RUN is ignored; the first batch's result is unchanged, and start is accepted again only after ack.
REQ-031 reset asserted during the 3rd RUN cycle of a num=8 batch -> next cycle busy=0, done=0, sum=0; no done for 20 cycles afterwards.
